// File: rtl/usb_bulk_in_arbiter_pkg.sv
// usb_bulk_in_arbiter_pkg
//   Shared definitions for the bulk IN arbiter and the core's bulk endpoint:
//   arbiter FSM state encoding and USB bulk max-packet sizes.
package usb_bulk_in_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    localparam int unsigned HS_MAXPKT_BYTES = 512;
    localparam int unsigned FS_MAXPKT_BYTES = 64;

endpackage : usb_bulk_in_arbiter_pkg

// File: rtl/usb_arb_rr2.sv
// usb_arb_rr2
//   Two-way grant picker, purely combinational.
//   Build option: USB_ARB_FIXED_PRIORITY_EN -- when defined, req[0] always
//   wins and ptr is ignored; otherwise round-robin using ptr.
// Ports:
//   req    [1:0] requests (bit i = source i valid)
//   ptr          preferred source for the next grant (0 = s0, 1 = s1)
//   enable       picker may grant only when high
//   grant  [1:0] one-hot grant, '0 when nothing granted
module usb_arb_rr2
    import usb_bulk_in_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
`ifdef USB_ARB_FIXED_PRIORITY_EN
            if (req[0])      grant = 2'b01;
            else if (req[1]) grant = 2'b10;
`else
            if (ptr) begin
                if (req[1])      grant = 2'b10;
                else if (req[0]) grant = 2'b01;
            end else begin
                if (req[0])      grant = 2'b01;
                else if (req[1]) grant = 2'b10;
            end
`endif
        end
    end

endmodule : usb_arb_rr2

// File: rtl/usb_bulk_in_arbiter.sv
// usb_bulk_in_arbiter
//   Two-source scheduler for the core's bulk IN AXI-Stream input. Grants one
//   source per frame (until that source's tlast), round-robin between frames,
//   and splits frames into max-packet sized USB packets with one idle GAP
//   cycle between packets. Data path is combinational while in XFER.
//   Build option: USB_ARB_FIXED_PRIORITY_EN (see usb_arb_rr2) -- s0 priority.
// Ports:
//   clock, reset (async, active-high)
//   configured_i      arbitration enabled only while high
//   usb_hs_enabled_i  selects HS_MAXPKT / FS_MAXPKT, latched per packet
//   blk_in_ready_o    granted source has data (XFER only)
//   grant_o [1:0]     one-hot owner, '0 when idle
//   s0_*/s1_*         source AXI-Stream slaves
//   m_*               master stream to the core's s_axis
module usb_bulk_in_arbiter
    import usb_bulk_in_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned HS_MAXPKT = HS_MAXPKT_BYTES,
    parameter int unsigned FS_MAXPKT = FS_MAXPKT_BYTES,
    parameter int unsigned CBITS     = 10
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             configured_i,
    input  logic             usb_hs_enabled_i,
    output logic             blk_in_ready_o,
    output logic [1:0]       grant_o,
    input  logic             s0_tvalid_i,
    output logic             s0_tready_o,
    input  logic             s0_tlast_i,
    input  logic [WIDTH-1:0] s0_tdata_i,
    input  logic             s1_tvalid_i,
    output logic             s1_tready_o,
    input  logic             s1_tlast_i,
    input  logic [WIDTH-1:0] s1_tdata_i,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [WIDTH-1:0] m_tdata_o
);

    arb_state_t       state;
    logic [1:0]       grant_q;
    logic [CBITS-1:0] cnt;
    logic [CBITS-1:0] maxpkt_m1;
    logic [CBITS-1:0] pkt_limit;
    logic             frame_end;   // last packet's final beat carried source tlast
    logic             rr_ptr;      // preferred source at next IDLE grant
    logic [1:0]       pick;

    logic             xfer;
    logic             sel;
    logic             g_valid;
    logic             g_last;
    logic [WIDTH-1:0] g_data;
    logic             beat;

    assign pkt_limit = usb_hs_enabled_i ? CBITS'(HS_MAXPKT - 1) : CBITS'(FS_MAXPKT - 1);

    usb_arb_rr2 u_pick (
        .req    ({s1_tvalid_i, s0_tvalid_i}),
        .ptr    (rr_ptr),
        .enable ((state == ST_IDLE) && configured_i),
        .grant  (pick)
    );

    // Zero-latency mux; every output is forced to 0 outside XFER so reset
    // and IDLE/GAP values need no extra registers.
    assign xfer    = (state == ST_XFER);
    assign sel     = grant_q[1];
    assign g_valid = sel ? s1_tvalid_i : s0_tvalid_i;
    assign g_last  = sel ? s1_tlast_i  : s0_tlast_i;
    assign g_data  = sel ? s1_tdata_i  : s0_tdata_i;

    assign grant_o        = grant_q;
    assign m_tvalid_o     = xfer & g_valid;
    assign m_tdata_o      = xfer ? g_data : '0;
    assign m_tlast_o      = xfer & (g_last | (cnt == maxpkt_m1));
    assign blk_in_ready_o = xfer & g_valid;
    assign s0_tready_o    = xfer & ~sel & m_tready_i;
    assign s1_tready_o    = xfer &  sel & m_tready_i;
    assign beat           = m_tvalid_o & m_tready_i;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant_q   <= '0;
            cnt       <= '0;
            maxpkt_m1 <= '0;
            frame_end <= 1'b0;
            rr_ptr    <= 1'b0;
        end else if (!configured_i) begin
            // Abandon any packet in flight; unaccepted bytes stay in the source.
            state   <= ST_IDLE;
            grant_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|pick) begin
                        grant_q   <= pick;
                        cnt       <= '0;
                        maxpkt_m1 <= pkt_limit;
                        state     <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (beat) begin
                        cnt <= cnt + CBITS'(1);
                        if (m_tlast_o) begin
                            frame_end <= g_last;
                            state     <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (frame_end) begin
                        rr_ptr  <= grant_q[0];
                        grant_q <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt       <= '0;
                        maxpkt_m1 <= pkt_limit;
                        state     <= ST_XFER;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : usb_bulk_in_arbiter

// File: tb/tb_usb_bulk_in_arbiter.sv
// tb_usb_bulk_in_arbiter
//   Scoreboard bench: each loaded frame pushes its expected beats (data and
//   expected m_tlast) into a per-source queue; output beats pop and compare.
module tb_usb_bulk_in_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       configured_i;
    logic       usb_hs_enabled_i;
    logic       blk_in_ready_o;
    logic [1:0] grant_o;
    logic       s0_tvalid_i, s0_tready_o, s0_tlast_i;
    logic [7:0] s0_tdata_i;
    logic       s1_tvalid_i, s1_tready_o, s1_tlast_i;
    logic [7:0] s1_tdata_i;
    logic       m_tvalid_o, m_tready_i, m_tlast_o;
    logic [7:0] m_tdata_o;

    usb_bulk_in_arbiter #(
        .WIDTH     (8),
        .HS_MAXPKT (512),
        .FS_MAXPKT (64),
        .CBITS     (10)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .configured_i     (configured_i),
        .usb_hs_enabled_i (usb_hs_enabled_i),
        .blk_in_ready_o   (blk_in_ready_o),
        .grant_o          (grant_o),
        .s0_tvalid_i      (s0_tvalid_i),
        .s0_tready_o      (s0_tready_o),
        .s0_tlast_i       (s0_tlast_i),
        .s0_tdata_i       (s0_tdata_i),
        .s1_tvalid_i      (s1_tvalid_i),
        .s1_tready_o      (s1_tready_o),
        .s1_tlast_i       (s1_tlast_i),
        .s1_tdata_i       (s1_tdata_i),
        .m_tvalid_o       (m_tvalid_o),
        .m_tready_i       (m_tready_i),
        .m_tlast_o        (m_tlast_o),
        .m_tdata_o        (m_tdata_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       f;
    } exp_t;

    logic [8:0]  sq0[$];
    logic [8:0]  sq1[$];
    exp_t        exp0[$];
    exp_t        exp1[$];
    logic [1:0]  gseq[$];

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned beats      = 0;
    int unsigned tlast_cnt  = 0;
    logic        prev_tlast = 1'b0;
    logic        throttle   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_srcs();
        s0_tvalid_i = (sq0.size() > 0);
        s0_tdata_i  = (sq0.size() > 0) ? sq0[0][7:0] : 8'h00;
        s0_tlast_i  = (sq0.size() > 0) ? sq0[0][8]   : 1'b0;
        s1_tvalid_i = (sq1.size() > 0);
        s1_tdata_i  = (sq1.size() > 0) ? sq1[0][7:0] : 8'h00;
        s1_tlast_i  = (sq1.size() > 0) ? sq1[0][8]   : 1'b0;
    endtask

    task automatic load_frame(input int src, input int unsigned len, input int unsigned maxpkt);
        exp_t e;
        logic [7:0] d;
        for (int unsigned i = 0; i < len; i++) begin
            d   = 8'($urandom);
            e.d = d;
            e.l = (i == len - 1) || ((i % maxpkt) == maxpkt - 1);
            e.f = (i == 0);
            if (src == 0) begin
                sq0.push_back({i == len - 1, d});
                exp0.push_back(e);
            end else begin
                sq1.push_back({i == len - 1, d});
                exp1.push_back(e);
            end
        end
        drive_srcs();
    endtask

    task automatic monitor();
        exp_t e;
        logic m_fire;
        m_fire = m_tvalid_o & m_tready_i;
        if (prev_tlast) begin
            check("gap_tvalid", m_tvalid_o, 0);
            check("gap_blk_rdy", blk_in_ready_o, 0);
        end
        check("s0_trdy_ungranted", s0_tready_o & (grant_o != 2'b01), 0);
        check("s1_trdy_ungranted", s1_tready_o & (grant_o != 2'b10), 0);
        if (m_fire) begin
            check("beat_blk_rdy", blk_in_ready_o, 1);
            if (grant_o == 2'b01 && exp0.size() > 0) begin
                e = exp0.pop_front();
            end else if (grant_o == 2'b10 && exp1.size() > 0) begin
                e = exp1.pop_front();
            end else begin
                check("beat_unexpected_grant", grant_o, 0);
                e.d = 8'h00; e.l = 1'b0; e.f = 1'b0;
            end
            check("beat_data_last", {m_tlast_o, m_tdata_o}, {e.l, e.d});
            if (e.f) gseq.push_back(grant_o);
            beats++;
            if (m_tlast_o) tlast_cnt++;
        end
        prev_tlast = m_fire & m_tlast_o;
    endtask

    task automatic tick();
        logic f0, f1;
        @(negedge clock);
        f0 = s0_tvalid_i & s0_tready_o;
        f1 = s1_tvalid_i & s1_tready_o;
        if (!reset) monitor();
        @(posedge clock);
        #1;
        if (f0 && sq0.size() > 0) sq0.delete(0);
        if (f1 && sq1.size() > 0) sq1.delete(0);
        if (throttle) m_tready_i = 1'($urandom_range(0, 1));
        drive_srcs();
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while ((sq0.size() + sq1.size() + exp0.size() + exp1.size()) != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", sq0.size() + sq1.size() + exp0.size() + exp1.size(), 0);
        tick();
        tick();
        check("grant_release", grant_o, 0);
    endtask

    initial begin
        exp_t e;
        reset            = 1'b1;
        configured_i     = 1'b0;
        usb_hs_enabled_i = 1'b1;
        m_tready_i       = 1'b1;
        drive_srcs();
        #12;
        check("rst_grant", grant_o, 0);
        check("rst_blk", blk_in_ready_o, 0);
        check("rst_mvalid", m_tvalid_o, 0);
        check("rst_mlast", m_tlast_o, 0);
        check("rst_mdata", m_tdata_o, 0);
        check("rst_trdy", {s1_tready_o, s0_tready_o}, 0);
        @(posedge clock); #1;
        reset        = 1'b0;
        configured_i = 1'b1;

        // HS 1200-byte frame from s0: 512 + 512 + 176
        tlast_cnt = 0; gseq.delete();
        load_frame(0, 1200, 512);
        drain(3000);
        check("hs1200_pkts", tlast_cnt, 3);
        check("hs1200_grant", gseq.size() == 1 ? gseq[0] : 2'b11, 2'b01);

        // FS exactly 64 bytes from s1; HS flips after packet start and is ignored
        usb_hs_enabled_i = 1'b0;
        tlast_cnt = 0; gseq.delete();
        load_frame(1, 64, 64);
        tick();
        usb_hs_enabled_i = 1'b1;
        drain(500);
        check("fs64_pkts", tlast_cnt, 1);

        // Both sources continuously valid, four 10-byte frames each
        gseq.delete();
        for (int k = 0; k < 4; k++) begin
            load_frame(0, 10, 512);
            load_frame(1, 10, 512);
        end
        drain(1000);
        check("rr_frames", gseq.size(), 8);
        for (int i = 0; i < 8 && i < gseq.size(); i++) begin
`ifdef USB_ARB_FIXED_PRIORITY_EN
            check("rr_grant_seq", gseq[i], (i < 4) ? 2'b01 : 2'b10);
`else
            check("rr_grant_seq", gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
        end

        // 700-byte HS frame with random m_tready throttling: 512 + 188
        tlast_cnt = 0; beats = 0;
        throttle = 1'b1;
        load_frame(0, 700, 512);
        drain(5000);
        throttle = 1'b0; m_tready_i = 1'b1;
        check("thr_pkts", tlast_cnt, 2);
        check("thr_beats", beats, 700);

        // configured_i drop after byte 100 of a 700-byte frame
        beats = 0;
        load_frame(0, 700, 512);
        for (int unsigned n = 0; beats < 100 && n < 1000; n++) tick();
        check("cfg_reached_100", beats, 100);
        configured_i = 1'b0;
        tick();
        check("cfg_drop_grant", grant_o, 0);
        check("cfg_drop_s0trdy", s0_tready_o, 0);
        check("cfg_drop_mvalid", m_tvalid_o, 0);
        // Packet count restarts from zero on the fresh grant.
        exp0.delete();
        for (int unsigned i = 0; i < sq0.size(); i++) begin
            e.d = sq0[i][7:0];
            e.l = sq0[i][8] || ((i % 512) == 511);
            e.f = (i == 0);
            exp0.push_back(e);
        end
        configured_i = 1'b1;
        tick();
        check("cfg_regrant", grant_o, 2'b01);
        tlast_cnt = 0;
        drain(2000);
        check("cfg_resume_pkts", tlast_cnt, 2);

        // Asynchronous reset mid-XFER
        beats = 0;
        load_frame(0, 50, 512);
        for (int unsigned n = 0; beats < 6 && n < 100; n++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("arst_grant", grant_o, 0);
        check("arst_blk", blk_in_ready_o, 0);
        check("arst_mvalid", m_tvalid_o, 0);
        check("arst_mlast", m_tlast_o, 0);
        check("arst_mdata", m_tdata_o, 0);
        check("arst_trdy", {s1_tready_o, s0_tready_o}, 0);
        sq0.delete(); sq1.delete(); exp0.delete(); exp1.delete();
        prev_tlast = 1'b0;
        drive_srcs();
        @(posedge clock); #3;
        reset = 1'b0;
        @(posedge clock); #1;
        // Last grant before reset was s0; a reset pointer must still favour s0.
        gseq.delete();
        load_frame(0, 5, 512);
        load_frame(1, 5, 512);
        drain(200);
        check("arst_ptr_n", gseq.size(), 2);
        check("arst_ptr_first", gseq.size() > 0 ? gseq[0] : 2'b11, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_usb_bulk_in_arbiter

// File: doc/usb_bulk_in_arbiter.md
Name: usb_bulk_in_arbiter

Overview:
Two-requester scheduler for the single bulk IN AXI-Stream path of the ULPI USB core. It grants one source per frame (a frame ends at that source's tlast), round-robin between sources. It splits long frames into USB packets of max-packet size: 512 B at high-speed, 64 B at full-speed. It drives the core's bulk-IN ready indication and sits between user data producers (loopback FIFO, status/telemetry stream) and the core's s_axis input, in the usb_clock domain.

Parameters:
WIDTH, 8, data byte width of all streams (tdata bits)
HS_MAXPKT, 512, max packet bytes when high-speed enabled
FS_MAXPKT, 64, max packet bytes at full-speed
CBITS, 10, packet byte-counter width; must satisfy 2**CBITS >= HS_MAXPKT

Ports:
clock  input  1  usb_clock from the USB core
reset  input  1  asynchronous, active-high reset
configured_i  input  1  device configured; arbitration enabled only when high
usb_hs_enabled_i  input  1  selects HS_MAXPKT (1) or FS_MAXPKT (0); sampled at start of each packet
blk_in_ready_o  output  1  data available for an IN packet
grant_o  output  2  one-hot current owner; 2'b00 when idle
s0_tvalid_i / s0_tready_o / s0_tlast_i / s0_tdata_i  in/out/in/in  1/1/1/WIDTH  source 0 stream
s1_tvalid_i / s1_tready_o / s1_tlast_i / s1_tdata_i  in/out/in/in  1/1/1/WIDTH  source 1 stream
m_tvalid_o / m_tready_i / m_tlast_o / m_tdata_o  out/in/out/out  1/1/1/WIDTH  to core s_axis

Behaviour:
- Reset values: grant_o=0, blk_in_ready_o=0, m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, s*_tready_o=0. State is IDLE, byte counter 0, round-robin pointer points at s0.
- FSM states IDLE, XFER, GAP.
- IDLE: when configured_i=1 and any s*_tvalid_i=1, grant a source.
  - Round-robin: the source after the last-granted one wins if valid, otherwise the other.
  - grant_o registers next cycle; state goes to XFER; counter cleared; max-packet size latched from usb_hs_enabled_i.
- XFER: combinational mux.
  - m_tvalid_o = granted tvalid; m_tdata_o = granted tdata.
  - Granted tready = m_tready_i. Ungranted tready = 0.
  - blk_in_ready_o = granted tvalid while in XFER, 0 otherwise.
  - Each beat (m_tvalid_o & m_tready_i) increments the counter.
  - m_tlast_o = source tlast OR (counter == maxpkt-1).
  - Beat with m_tlast_o goes to GAP.
- GAP: one cycle; all tready=0, m_tvalid_o=0.
  - If the last beat carried source tlast: release grant (grant_o=0), update round-robin pointer, go to IDLE.
  - Else, split frame: keep grant, clear counter, relatch max-packet size, go to XFER.
- Exact multiple: a frame of exactly maxpkt bytes has its source tlast coincide with the count limit. Single tlast, frame ends, no extra packet.
- Simultaneous requests in IDLE: round-robin decides; a lone requester always wins regardless of pointer.
- configured_i falling in any state: next cycle returns to IDLE, grant_o=0, all tready=0. Bytes not yet accepted remain in the source. A partially sent packet is abandoned without tlast (core is resetting).
- usb_hs_enabled_i change mid-packet: ignored until next packet start.
- Latency: grant 1 cycle after request in IDLE; data path zero-latency (no registers) in XFER.

Optional Feature:
USB_ARB_FIXED_PRIORITY_EN
- Defined: s0 always wins in IDLE when valid; the round-robin pointer is removed.
- Undefined: round-robin as above.
- Frame-granular holding and GAP behaviour are identical in both builds.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, XFER=2'd1, GAP=2'd2), HS/FS max-packet constants (512/64), shared with the USB core's bulk endpoint.
- One natural sub-module: usb_arb_rr2, a two-way round-robin/priority grant picker. Inputs: req[1:0], last-grant pointer, enable. Output: one-hot grant. The macro lives inside it.

Test Plan:
- HS, s0 sends 1200-byte frame with continuous m_tready -> three packets of 512, 512, 176; m_tlast on beats 512/1024/1200; one GAP cycle between; grant_o=01 throughout, 00 after.
- FS, s1 sends exactly 64 bytes -> single packet with one tlast, no zero-length follow-on; grant released after GAP.
- Both sources valid continuously, 10-byte frames each -> grants alternate 01,10,01,10; with USB_ARB_FIXED_PRIORITY_EN -> 01 every frame.
- Random m_tready throttling (50%) during a 700-byte HS frame -> byte-exact output order; packets 512 + 188; no beat lost or duplicated.
- configured_i dropped at byte 100 of a packet -> next cycle grant_o=0, s0_tready_o=0, m_tvalid_o=0; re-raise -> fresh grant, counter restarts at 0.
- reset asserted mid-XFER (asynchronous, between clock edges) -> all outputs 0 immediately; after release IDLE, pointer at s0.
